// File: rtl/ctrl_types_pkg.sv
// Operation encodings and controller FSM states for the cache controller.
package ctrl_types_pkg;

    typedef enum logic [1:0] {
        NOOP   = 2'd0,
        READ   = 2'd1,
        UPSERT = 2'd2,
        DELETE = 2'd3
    } operation_e;

    typedef enum logic [1:0] {
        CTRL_ST_IDLE    = 2'd0,
        CTRL_ST_SEARCH  = 2'd1,
        CTRL_ST_RESPOND = 2'd2,
        CTRL_ST_RELEASE = 2'd3
    } ctrl_state_e;

    // Operations that walk the table; anything else is answered with a failure.
    function automatic logic is_searchable(input operation_e op);
        return (op == READ) || (op == UPSERT) || (op == DELETE);
    endfunction

endpackage

// File: rtl/if_types_pkg.sv
// Shared field widths of the OBI cache interface.
package if_types_pkg;
    localparam int KEY_WIDTH   = 32;
    localparam int VALUE_WIDTH = 32;
endpackage

// File: rtl/kv_store_array.sv
// Key-value slot storage: per-slot valid/key/value, one combinational read
// port and one write port with set-entry and clear-valid commands.
module kv_store_array #(
    parameter  int NUM_ENTRIES = 8,
    parameter  int KEY_WIDTH   = 32,
    parameter  int VALUE_WIDTH = 32,
    localparam int IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [IDX_W-1:0]       i_rd_idx,
    output logic                   o_rd_valid,
    output logic [KEY_WIDTH-1:0]   o_rd_key,
    output logic [VALUE_WIDTH-1:0] o_rd_value,
    input  logic                   i_wr_set,
    input  logic                   i_wr_clear,
    input  logic [IDX_W-1:0]       i_wr_idx,
    input  logic [KEY_WIDTH-1:0]   i_wr_key,
    input  logic [VALUE_WIDTH-1:0] i_wr_value
);

    logic [NUM_ENTRIES-1:0] r_valid;
    logic [KEY_WIDTH-1:0]   r_key   [NUM_ENTRIES];
    logic [VALUE_WIDTH-1:0] r_value [NUM_ENTRIES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_wr_set) begin
            r_valid[i_wr_idx] <= 1'b1;
        end else if (i_wr_clear) begin
            r_valid[i_wr_idx] <= 1'b0;
        end
    end

    // Key/value contents are don't-care after reset, so they carry no reset.
    always_ff @(posedge clk) begin
        if (i_wr_set) begin
            r_key[i_wr_idx]   <= i_wr_key;
            r_value[i_wr_idx] <= i_wr_value;
        end
    end

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_key   = r_key[i_rd_idx];
    assign o_rd_value = r_value[i_rd_idx];

endmodule

// File: rtl/cache_controller.sv
// Executes READ/UPSERT/DELETE against a key-value table using a sequential
// linear search, answering each request with a one-cycle ready pulse.
module cache_controller
    import ctrl_types_pkg::*;
#(
    parameter  int NUM_ENTRIES = 8,
    parameter  int KEY_WIDTH   = if_types_pkg::KEY_WIDTH,
    parameter  int VALUE_WIDTH = if_types_pkg::VALUE_WIDTH,
    localparam int IDX_W       = $clog2(NUM_ENTRIES),
    localparam int CNT_W       = $clog2(NUM_ENTRIES + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  operation_e             operation_in,
    input  logic [KEY_WIDTH-1:0]   key_in,
    input  logic [VALUE_WIDTH-1:0] value_in,
    output logic                   ready_out,
    output logic                   op_succ_out,
    output logic [VALUE_WIDTH-1:0] value_out,
    output logic [CNT_W-1:0]       count_out,
    output logic                   full_out
);

    ctrl_state_e            r_state;
    ctrl_state_e            w_state_next;

    operation_e             r_op;
    logic [KEY_WIDTH-1:0]   r_key;
    logic [VALUE_WIDTH-1:0] r_value;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_hit;
    logic [IDX_W-1:0]       r_hit_idx;
    logic                   r_free_found;
    logic [IDX_W-1:0]       r_free_idx;
    logic [CNT_W-1:0]       r_count;
    logic                   r_full;
    logic                   r_op_succ;
    logic [VALUE_WIDTH-1:0] r_value_out;

    logic                   w_rd_valid;
    logic [KEY_WIDTH-1:0]   w_rd_key;
    logic [VALUE_WIDTH-1:0] w_rd_value;
    logic                   w_match;
    logic                   w_last;
    logic                   w_free_avail;
    logic                   w_ready;
    logic                   w_wr_set;
    logic                   w_wr_clear;
    logic [IDX_W-1:0]       w_wr_idx;
    logic [CNT_W-1:0]       w_count_next;

    kv_store_array #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .KEY_WIDTH   (KEY_WIDTH),
        .VALUE_WIDTH (VALUE_WIDTH)
    ) u_store (
        .clk        (clk),
        .rst        (rst),
        .i_rd_idx   (r_idx),
        .o_rd_valid (w_rd_valid),
        .o_rd_key   (w_rd_key),
        .o_rd_value (w_rd_value),
        .i_wr_set   (w_wr_set),
        .i_wr_clear (w_wr_clear),
        .i_wr_idx   (w_wr_idx),
        .i_wr_key   (r_key),
        .i_wr_value (r_value)
    );

    assign w_match      = w_rd_valid && (w_rd_key == r_key);
    assign w_last       = (r_idx == IDX_W'(NUM_ENTRIES - 1));
    assign w_free_avail = r_free_found || !w_rd_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= CTRL_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            CTRL_ST_IDLE: begin
                if (operation_in != NOOP) begin
                    w_state_next = is_searchable(operation_in) ? CTRL_ST_SEARCH : CTRL_ST_RESPOND;
                end
            end
            CTRL_ST_SEARCH: begin
                if (w_match || w_last) begin
                    w_state_next = CTRL_ST_RESPOND;
                end
            end
            CTRL_ST_RESPOND: w_state_next = CTRL_ST_RELEASE;
            CTRL_ST_RELEASE: begin
                if (operation_in == NOOP) begin
                    w_state_next = CTRL_ST_IDLE;
                end
            end
            default: w_state_next = CTRL_ST_IDLE;
        endcase
    end

    // The table write is committed in RESPOND using results latched on entry.
    always_comb begin
        w_ready      = (r_state == CTRL_ST_RESPOND);
        w_wr_set     = w_ready && (r_op == UPSERT) && r_op_succ;
        w_wr_clear   = w_ready && (r_op == DELETE) && r_hit;
        w_wr_idx     = r_hit ? r_hit_idx : r_free_idx;
        w_count_next = r_count;
        if (w_wr_set && !r_hit) begin
            w_count_next = r_count + CNT_W'(1);
        end else if (w_wr_clear) begin
            w_count_next = r_count - CNT_W'(1);
        end
    end

    // Results are registered on the edge into RESPOND so they are valid with ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op         <= NOOP;
            r_key        <= '0;
            r_value      <= '0;
            r_idx        <= '0;
            r_hit        <= 1'b0;
            r_hit_idx    <= '0;
            r_free_found <= 1'b0;
            r_free_idx   <= '0;
            r_count      <= '0;
            r_full       <= 1'b0;
            r_op_succ    <= 1'b0;
            r_value_out  <= '0;
        end else begin
            case (r_state)
                CTRL_ST_IDLE: begin
                    if (operation_in != NOOP) begin
                        r_op         <= operation_in;
                        r_key        <= key_in;
                        r_value      <= value_in;
                        r_idx        <= '0;
                        r_hit        <= 1'b0;
                        r_free_found <= 1'b0;
                        if (!is_searchable(operation_in)) begin
                            r_op_succ   <= 1'b0;
                            r_value_out <= '0;
                        end
                    end
                end
                CTRL_ST_SEARCH: begin
                    if (!r_free_found && !w_rd_valid) begin
                        r_free_found <= 1'b1;
                        r_free_idx   <= r_idx;
                    end
                    if (w_match) begin
                        r_hit       <= 1'b1;
                        r_hit_idx   <= r_idx;
                        r_op_succ   <= 1'b1;
                        r_value_out <= (r_op == UPSERT) ? r_value : w_rd_value;
                    end else if (w_last) begin
                        if ((r_op == UPSERT) && w_free_avail) begin
                            r_op_succ   <= 1'b1;
                            r_value_out <= r_value;
                        end else begin
                            r_op_succ   <= 1'b0;
                            r_value_out <= '0;
                        end
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                CTRL_ST_RESPOND: begin
                    r_count <= w_count_next;
                    r_full  <= (w_count_next == CNT_W'(NUM_ENTRIES));
                end
                default: ;
            endcase
        end
    end

    assign ready_out   = w_ready;
    assign op_succ_out = r_op_succ;
    assign value_out   = r_value_out;
    assign count_out   = r_count;
    assign full_out    = r_full;

endmodule

// File: doc/cache_controller.md
# cache_controller

Downstream consumer of the OBI cache interface. Takes the decoded operation, key and value and executes it against an on-chip key-value table of NUM_ENTRIES slots. Uses a sequential linear search, one entry per cycle. Returns a one-cycle ready pulse with success flag and result value, which the interface forwards on its R channel.

## Interface
Parameters:
- NUM_ENTRIES, 8: number of key-value slots; power of two, ≥2.
- KEY_WIDTH, if_types_pkg::KEY_WIDTH: key width.
- VALUE_WIDTH, if_types_pkg::VALUE_WIDTH: value width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- operation_in  in  ctrl_types_pkg::operation_e  requested operation; NOOP = no request.
- key_in  in  KEY_WIDTH  request key.
- value_in  in  VALUE_WIDTH  request value (UPSERT only).
- ready_out  out  1  one-cycle completion pulse.
- op_succ_out  out  1  result flag, valid from ready_out onward.
- value_out  out  VALUE_WIDTH  result value, valid from ready_out onward.
- count_out  out  $clog2(NUM_ENTRIES+1)  number of valid entries.
- full_out  out  1  count_out == NUM_ENTRIES.

## Operation
- Storage: per slot a valid bit, key and value. Reset clears all valid bits; key and value contents are don't-care.
- FSM states are CTRL_ST_IDLE, CTRL_ST_SEARCH, CTRL_ST_RESPOND and CTRL_ST_RELEASE.
- IDLE:
  - When operation_in != NOOP, latch operation, key and value into internal registers and clear idx to 0.
  - If the operation is READ, UPSERT or DELETE, go to SEARCH.
  - For any other encoding, go directly to RESPOND with a failure result.
- SEARCH:
  - Each cycle, compare slot[idx] (valid && key match) and record the lowest-index invalid slot seen.
  - On a hit, record the hit index and go to RESPOND.
  - On a miss at idx == NUM_ENTRIES-1, go to RESPOND with no hit; otherwise increment idx.
- RESPOND: ready_out = 1 for exactly this cycle. Commit the table update and results:
  - READ hit: op_succ = 1, value_out = stored value.
  - READ miss: op_succ = 0, value_out = 0.
  - UPSERT hit: overwrite the value; op_succ = 1, value_out = new value.
  - UPSERT miss with a free slot: write key and value into the lowest-index free slot, set valid, count + 1; op_succ = 1, value_out = new value.
  - UPSERT miss with the table full: no change; op_succ = 0, value_out = 0.
  - DELETE hit: clear valid, count − 1; op_succ = 1, value_out = old value.
  - DELETE miss: op_succ = 0, value_out = 0.
  - Go to RELEASE.
- RELEASE: wait until operation_in == NOOP (the interface clears its request after completion), then go to IDLE. This prevents a held request from re-executing.
- op_succ_out and value_out are registered. They hold their values until the next RESPOND.
- count_out and full_out are registered. They update on the cycle after RESPOND.

## Timing
- Reset (asynchronous, immediate): state IDLE; ready_out, op_succ_out, count_out and full_out = 0; value_out = 0; all valid bits = 0. Reset mid-search aborts with no table update and no ready pulse.
- Let A be the IDLE cycle that sees a valid operation.
  - Hit at slot i: ready_out high at cycle A+2+i.
  - Miss: ready_out high at cycle A+1+NUM_ENTRIES.
  - Unsupported operation: ready_out high at A+1.
- ready_out is a Moore output (state == RESPOND); it is never high in two consecutive cycles.
- Inputs are sampled only in IDLE. Changes to operation_in, key_in or value_in during SEARCH, RESPOND or RELEASE are ignored.
- A NOOP→op transition can be accepted no earlier than the cycle after RELEASE observes NOOP, so back-to-back requests cost at least 1 idle cycle.
- Duplicate keys cannot arise, because UPSERT always searches all slots before allocating.

## Structure
- ctrl_types_pkg: add ctrl_state_e (the four states above). The existing operation_e (NOOP, READ, UPSERT, DELETE) is used unchanged.
- Sub-module kv_store_array:
  - Contents: valid, key and value registers for NUM_ENTRIES slots.
  - Read side: one indexed combinational read port returning valid, key and value.
  - Write side: one write port with set-entry (valid, key, value) and clear-valid commands.
- The controller holds the FSM, idx counter, free-slot tracker, hit index and occupancy counter.

## Test plan
- Reset, then READ key 0x11 → ready at A+1+8, op_succ = 0, value_out = 0, count_out = 0.
- UPSERT key 0x11 / value 0xDEAD_BEEF → allocates slot 0, op_succ = 1, count_out = 1. Then READ 0x11 → hit at slot 0, ready at A+2, value_out = 0xDEAD_BEEF.
- UPSERT 0x11 with 0x1234 (existing key) → count stays 1, READ returns 0x1234. DELETE 0x11 → op_succ = 1, value_out = 0x1234, count = 0. A second DELETE 0x11 → op_succ = 0.
- Fill all 8 slots with keys 1..8 → full_out = 1. UPSERT key 9 → op_succ = 0, count stays 8. DELETE key 3, then UPSERT key 9 → lands in slot 2; READ 9 hits at A+4.
- Hold operation_in = READ for 20 cycles after ready → exactly one ready pulse. Drop to NOOP, reissue → second pulse.
- Assert rst during SEARCH of an UPSERT → no ready pulse, count_out = 0, all outputs 0 immediately. A subsequent READ misses.
